// File: rtl/miner_pkg.sv
// miner_pkg: types and widths shared by the golden nonce queue.
package miner_pkg;
  localparam int NONCE_W = 32;
  localparam int DROP_W = 8;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} gnq_state_t;
endpackage

// File: rtl/gnq_fifo.sv
// gnq_fifo: circular nonce buffer; an extra pointer bit separates full from empty.
module gnq_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          accept_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic rd_en;
  assign count_o = wptr_q - rptr_q;
  assign empty_o = count_o == '0;
  assign rd_en = pop_i && !empty_o;
  // a full queue still takes a push when the head leaves in the same cycle
  assign accept_o = push_i && !flush_i && (!count_o[AW] || rd_en);
  assign head_o = mem_q[rptr_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + (AW+1)'(accept_o);
      rptr_q <= flush_i ? wptr_q : rptr_q + (AW+1)'(rd_en);
    end
  always_ff @(posedge clk)
    if (accept_o) mem_q[wptr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue: buffers golden nonces and meters them one word at a time
// into the serial transmitter via its send/busy handshake.
module golden_nonce_queue
  import miner_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DEDUP = 1,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     nonce_valid,
  input  logic [NONCE_W-1:0]       nonce,
  input  logic                     flush,
  input  logic                     busy,
  output logic                     send,
  output logic [NONCE_W-1:0]       word,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_count
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  gnq_state_t state_q, state_d;
  logic [NONCE_W-1:0] word_q, word_d, last_q, last_d, head;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic lvalid_q, lvalid_d, pop, empty, accepted, dup, push_req;
  gnq_fifo #(.DEPTH(DEPTH), .W(NONCE_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push_req), .pop_i(pop), .flush_i(flush),
    .din_i(nonce), .head_o(head), .count_o(count), .empty_o(empty), .accept_o(accepted)
  );
  assign dup = (DEDUP != 0) && lvalid_q && nonce == last_q;
  assign push_req = nonce_valid && !flush && !dup;
  assign send = state_q == SEND;
  assign word = word_q;
  assign drop_count = drop_q;
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    tmr_d = tmr_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty && !busy) begin
        state_d = SEND;
        word_d = head;
        pop = 1'b1;
      end
      SEND: begin
        state_d = WAIT_BUSY;
        tmr_d = '0;
      end
      // no busy within the timeout: the word is written off, not retried
      WAIT_BUSY: if (busy) state_d = WAIT_DONE;
        else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) state_d = IDLE;
        else tmr_d = tmr_q + 1'b1;
      WAIT_DONE: if (!busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign drop_d = (push_req && !accepted && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  assign last_d = accepted ? nonce : last_q;
  assign lvalid_d = flush ? 1'b0 : accepted ? 1'b1 : lvalid_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      word_q <= '0;
      tmr_q <= '0;
      drop_q <= '0;
      last_q <= '0;
      lvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      tmr_q <= tmr_d;
      drop_q <= drop_d;
      last_q <= last_d;
      lvalid_q <= lvalid_d;
    end
endmodule

// File: tb/tb_golden_nonce_queue.sv
// tb_golden_nonce_queue: directed scenarios with a word scoreboard and a simple transmitter model.
module tb_golden_nonce_queue;
  logic clk = 0, rst_n = 0, nonce_valid = 0, flush = 0, hold = 0, never = 0;
  logic busy, busy1, send, send1, prev_send = 0, prev_busy = 0;
  logic [31:0] nonce = 0, word, word1;
  logic [3:0] count, count1;
  logic [7:0] drop_count, drop1;
  int bt = 0, cyc = 0, passed = 0, total = 0, n0 = 0, n1 = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  assign busy = hold || bt != 0;
  assign busy1 = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!never && send) bt <= 5;
    else if (bt != 0) bt <= bt - 1;
  end
  golden_nonce_queue #(.DEPTH(8), .DEDUP(1), .BUSY_TIMEOUT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .nonce_valid(nonce_valid), .nonce(nonce), .flush(flush),
    .busy(busy), .send(send), .word(word), .count(count), .drop_count(drop_count)
  );
  golden_nonce_queue #(.DEPTH(8), .DEDUP(0), .BUSY_TIMEOUT(4)) u_nodedup (
    .clk(clk), .rst_n(rst_n), .nonce_valid(nonce_valid), .nonce(nonce), .flush(flush),
    .busy(busy1), .send(send1), .word(word1), .count(count1), .drop_count(drop1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_send(input string tag);
    int k = 0;
    while (send !== 1'b1 && k < 60) begin
      step();
      k++;
    end
    chk(tag, 32'(k < 60), 1);
  endtask
  task automatic strobe(input logic [31:0] v, input bit expect_sent);
    nonce = v;
    nonce_valid = 1;
    if (expect_sent) exp_q.push_back(v);
    step();
    nonce_valid = 0;
  endtask
  always @(negedge clk) begin
    if (send) begin
      n0 <= n0 + 1;
      chk("sb_underflow", 32'(exp_q.size() == 0), 0);
      if (exp_q.size() != 0) chk("word", word, exp_q.pop_front());
      chk("busy_at_decision", 32'(prev_busy), 0);
      chk("send_consec", 32'(prev_send), 0);
    end
    if (send1) n1 <= n1 + 1;
    prev_send <= send;
    prev_busy <= busy;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int a0, a1, t0, k;
    repeat (3) step();
    chk("rst_send", 32'(send), 0);
    chk("rst_word", word, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_drop", 32'(drop_count), 0);
    rst_n = 1;
    step();
    strobe(32'hFFBD9207, 1);
    chk("lat_count_N", 32'(count), 1);
    chk("lat_send_N", 32'(send), 0);
    step();
    chk("lat_send_N1", 32'(send), 1);
    chk("lat_word", word, 32'hFFBD9207);
    chk("lat_count_N1", 32'(count), 0);
    step();
    chk("lat_send_N2", 32'(send), 0);
    repeat (20) step();
    a0 = n0;
    a1 = n1;
    exp_q.push_back(32'h12345678);
    nonce = 32'h12345678;
    nonce_valid = 1;
    step();
    step();
    nonce_valid = 0;
    repeat (25) step();
    chk("dedup_sends", n0 - a0, 1);
    chk("nodedup_sends", n1 - a1, 2);
    chk("dedup_drop", 32'(drop_count), 0);
    hold = 1;
    step();
    for (int v = 1; v <= 10; v++) strobe(v, v <= 8);
    chk("burst_count", 32'(count), 8);
    chk("burst_drop", 32'(drop_count), 2);
    hold = 0;
    k = 0;
    while ((exp_q.size() != 0 || count != 0) && k < 150) begin
      step();
      k++;
    end
    chk("burst_drain_timeout", 32'(k < 150), 1);
    repeat (10) step();
    chk("burst_left", exp_q.size(), 0);
    hold = 1;
    step();
    strobe(32'hA1, 1);
    strobe(32'hA2, 0);
    strobe(32'hA3, 0);
    chk("flush_pre_count", 32'(count), 3);
    a0 = n0;
    hold = 0;
    wait_send("flush_send_timeout");
    step();
    flush = 1;
    nonce_valid = 1;
    nonce = 32'hB1;
    step();
    flush = 0;
    nonce_valid = 0;
    chk("flush_count", 32'(count), 0);
    repeat (30) step();
    chk("flush_sends", n0 - a0, 1);
    chk("flush_count_end", 32'(count), 0);
    chk("flush_drop", 32'(drop_count), 2);
    never = 1;
    step();
    strobe(32'hC1, 1);
    strobe(32'hC2, 1);
    wait_send("tmo_first_timeout");
    t0 = cyc;
    step();
    wait_send("tmo_second_timeout");
    chk("tmo_gap", cyc - t0, 6);
    repeat (10) step();
    never = 0;
    hold = 1;
    step();
    strobe(32'hD1, 1);
    strobe(32'hD2, 0);
    strobe(32'hD3, 0);
    hold = 0;
    wait_send("rst_send_timeout");
    step();
    step();
    chk("pre_rst_count", 32'(count), 2);
    #2 rst_n = 0;
    #1;
    chk("async_send", 32'(send), 0);
    chk("async_word", word, 0);
    chk("async_count", 32'(count), 0);
    chk("async_drop", 32'(drop_count), 0);
    step();
    rst_n = 1;
    strobe(32'hE1, 1);
    chk("post_rst_busy", 32'(busy), 1);
    chk("post_rst_send", 32'(send), 0);
    chk("post_rst_count", 32'(count), 1);
    wait_send("post_rst_send_timeout");
    chk("post_rst_word", word, 32'hE1);
    repeat (20) step();
    chk("final_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
